// File: rtl/mc_ctrl_pkg.sv
// rtl/mc_ctrl_pkg.sv - shared types and encodings for the multicycle control unit
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH,
    DECODE,
    MEMADR,
    MEMRD,
    MEMWB,
    MEMWR,
    EXECUTER,
    EXECUTEI,
    ALUWB,
    BRANCH,
    UNKNOWN
  } state_t;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;

endpackage

// File: rtl/mc_cond_unit.sv
// rtl/mc_cond_unit.sv - ARM condition-field evaluation against stored NZCV
module mc_cond_unit
  import mc_ctrl_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       cond_ex
);

  logic n, z, c, v;
  assign {n, z, c, v} = flags;

  always_comb begin
    cond_ex = 1'b0;
    case (cond)
      COND_EQ: cond_ex = z;
      COND_NE: cond_ex = ~z;
      COND_CS: cond_ex = c;
      COND_CC: cond_ex = ~c;
      COND_MI: cond_ex = n;
      COND_PL: cond_ex = ~n;
      COND_VS: cond_ex = v;
      COND_VC: cond_ex = ~v;
      COND_HI: cond_ex = c & ~z;
      COND_LS: cond_ex = ~c | z;
      COND_GE: cond_ex = (n == v);
      COND_LT: cond_ex = (n != v);
      COND_GT: cond_ex = ~z & (n == v);
      COND_LE: cond_ex = z | (n != v);
      COND_AL: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// rtl/mc_controller.sv - multicycle FSM, ALU decode and NZCV flags for the ARM-subset core
module mc_controller
  import mc_ctrl_pkg::*;
#(
  parameter logic [3:0] FLAGS_RESET = 4'b0000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] Cond,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  input  logic [3:0] ALUFlags,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic [1:0] RegSrc,
  output logic       RegWrite,
  output logic [1:0] ALUControl
);

  state_t     state_q, state_d;
  logic [3:0] flags_q;
  logic       cond_ex, cond_ex_q, no_write_q;
  logic       next_pc, reg_w, mem_w, ir_w, branch, alu_op;
  logic       flag_w_nz, flag_w_cv, pcs;
  logic [3:0] cmd;

  assign cmd = Funct[4:1];

  mc_cond_unit u_cond (
    .cond    (Cond),
    .flags   (flags_q),
    .cond_ex (cond_ex)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= FETCH;
    else          state_q <= state_d;
  end

  // Condition and CMP's no-write are captured once in DECODE and held for the rest of the instruction.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      flags_q    <= FLAGS_RESET;
      cond_ex_q  <= 1'b0;
      no_write_q <= 1'b0;
    end else begin
      if (state_q == DECODE) begin
        cond_ex_q  <= cond_ex;
        no_write_q <= (Op == OP_DP) && (cmd == CMD_CMP);
      end
      if (flag_w_nz && cond_ex_q) flags_q[3:2] <= ALUFlags[3:2];
      if (flag_w_cv && cond_ex_q) flags_q[1:0] <= ALUFlags[1:0];
    end
  end

  always_comb begin
    state_d   = FETCH;
    next_pc   = 1'b0;
    reg_w     = 1'b0;
    mem_w     = 1'b0;
    ir_w      = 1'b0;
    branch    = 1'b0;
    alu_op    = 1'b0;
    AdrSrc    = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 2'b00;
    case (state_q)
      FETCH: begin
        ir_w = 1'b1; ALUSrcA = 1'b1; ALUSrcB = 2'b10; ResultSrc = 2'b10; next_pc = 1'b1;
        state_d = DECODE;
      end
      DECODE: begin
        ALUSrcA = 1'b1; ALUSrcB = 2'b10; ResultSrc = 2'b10;
        case (Op)
          OP_MEM:  state_d = MEMADR;
          OP_DP:   state_d = Funct[5] ? EXECUTEI : EXECUTER;
          OP_BR:   state_d = BRANCH;
          default: state_d = UNKNOWN;
        endcase
      end
      MEMADR: begin
        ALUSrcB = 2'b01;
        state_d = Funct[0] ? MEMRD : MEMWR;
      end
      MEMRD: begin
        AdrSrc = 1'b1; state_d = MEMWB;
      end
      MEMWB: begin
        ResultSrc = 2'b01; reg_w = 1'b1;
      end
      MEMWR: begin
        AdrSrc = 1'b1; mem_w = 1'b1;
      end
      EXECUTER: begin
        alu_op = 1'b1; state_d = ALUWB;
      end
      EXECUTEI: begin
        ALUSrcB = 2'b01; alu_op = 1'b1; state_d = ALUWB;
      end
      ALUWB: reg_w = 1'b1;
      BRANCH: begin
        ALUSrcB = 2'b01; ResultSrc = 2'b10; branch = 1'b1;
      end
      default: state_d = FETCH;
    endcase
  end

  // Unrecognised commands fall through as ADD with neither flag group written.
  always_comb begin
    ALUControl = ALU_ADD;
    flag_w_nz  = 1'b0;
    flag_w_cv  = 1'b0;
    if (alu_op) begin
      case (cmd)
        CMD_ADD: begin ALUControl = ALU_ADD; flag_w_nz = Funct[0]; flag_w_cv = Funct[0]; end
        CMD_SUB: begin ALUControl = ALU_SUB; flag_w_nz = Funct[0]; flag_w_cv = Funct[0]; end
        CMD_CMP: begin ALUControl = ALU_SUB; flag_w_nz = Funct[0]; flag_w_cv = Funct[0]; end
        CMD_AND: begin ALUControl = ALU_AND; flag_w_nz = Funct[0]; end
        CMD_ORR: begin ALUControl = ALU_ORR; flag_w_nz = Funct[0]; end
        default: ALUControl = ALU_ADD;
      endcase
    end
  end

  assign ImmSrc   = Op;
  assign RegSrc   = {Op == OP_MEM, Op == OP_BR};
  assign pcs      = ((Rd == 4'hF) & reg_w & ~no_write_q) | branch;
  assign IRWrite  = reset_n & ir_w;
  assign PCWrite  = reset_n & (next_pc | (pcs & cond_ex_q));
  assign RegWrite = reset_n & reg_w & cond_ex_q & ~no_write_q;
  assign MemWrite = reset_n & mem_w & cond_ex_q;

endmodule

// File: tb/tb_mc_controller.sv
// tb/tb_mc_controller.sv - scoreboard bench: per-cycle expected control vectors from an instruction-level model
module tb_mc_controller;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] Cond, Rd, ALUFlags;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, ALUSrcA, RegWrite;
  logic [1:0] ResultSrc, ALUSrcB, ImmSrc, RegSrc, ALUControl;

  int checks = 0;
  int failures = 0;
  logic [3:0]  mflags;
  logic [15:0] exp_q[$];
  string       tag_q[$];
  logic [15:0] obs;

  always #5 clk = ~clk;

  mc_controller #(.FLAGS_RESET(4'b0000)) dut (
    .clk(clk), .reset_n(reset_n), .Cond(Cond), .Op(Op), .Funct(Funct), .Rd(Rd),
    .ALUFlags(ALUFlags), .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ImmSrc(ImmSrc), .RegSrc(RegSrc), .RegWrite(RegWrite), .ALUControl(ALUControl)
  );

  assign obs = {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
                ImmSrc, RegSrc, RegWrite, ALUControl};

  function automatic logic [15:0] vec(input logic pcw, input logic adr, input logic memw,
                                      input logic irw, input logic [1:0] rs, input logic asa,
                                      input logic [1:0] asb, input logic [1:0] op,
                                      input logic regw, input logic [1:0] aluc);
    logic [1:0] rsrc;
    rsrc = {op == 2'b01, op == 2'b10};
    return {pcw, adr, memw, irw, rs, asa, asb, op, rsrc, regw, aluc};
  endfunction

  function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v, r;
    {n, z, cy, v} = f;
    case (c)
      4'd0: r = z;          4'd1: r = !z;
      4'd2: r = cy;         4'd3: r = !cy;
      4'd4: r = n;          4'd5: r = !n;
      4'd6: r = v;          4'd7: r = !v;
      4'd8: r = cy && !z;   4'd9: r = !cy || z;
      4'd10: r = !(n ^ v);  4'd11: r = n ^ v;
      4'd12: r = !z && !(n ^ v);
      4'd13: r = z || (n ^ v);
      4'd14: r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  task automatic check(input string tag, input logic [15:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
    end
  endtask

  // Called at a negedge while the DUT sits in FETCH; abort_at asserts reset in that cycle index.
  task automatic run_instr(input string nm, input logic [3:0] c, input logic [1:0] op,
                           input logic [5:0] fn, input logic [3:0] rd, input logic [3:0] af,
                           input int abort_at);
    logic ce, s, nw, known, arith;
    logic [1:0] aluc;
    logic [3:0] cmd;
    int i;
    Cond = c; Op = op; Funct = fn; Rd = rd; ALUFlags = af;
    ce = cond_ok(c, mflags);
    cmd = fn[4:1];
    s = fn[0];
    nw = (cmd == 4'b1010);
    known = 1'b1; arith = 1'b0;
    case (cmd)
      4'b0100: begin aluc = 2'b00; arith = 1'b1; end
      4'b0010: begin aluc = 2'b01; arith = 1'b1; end
      4'b1010: begin aluc = 2'b01; arith = 1'b1; end
      4'b0000: aluc = 2'b10;
      4'b1100: aluc = 2'b11;
      default: begin aluc = 2'b00; known = 1'b0; end
    endcase
    exp_q.push_back(vec(1, 0, 0, 1, 2'b10, 1, 2'b10, op, 0, 2'b00)); tag_q.push_back({nm, "_fetch"});
    exp_q.push_back(vec(0, 0, 0, 0, 2'b10, 1, 2'b10, op, 0, 2'b00)); tag_q.push_back({nm, "_decode"});
    case (op)
      2'b01: begin
        exp_q.push_back(vec(0, 0, 0, 0, 2'b00, 0, 2'b01, op, 0, 2'b00)); tag_q.push_back({nm, "_memadr"});
        if (fn[0]) begin
          exp_q.push_back(vec(0, 1, 0, 0, 2'b00, 0, 2'b00, op, 0, 2'b00)); tag_q.push_back({nm, "_memrd"});
          exp_q.push_back(vec(ce && rd == 4'hF, 0, 0, 0, 2'b01, 0, 2'b00, op, ce, 2'b00));
          tag_q.push_back({nm, "_memwb"});
        end else begin
          exp_q.push_back(vec(0, 1, ce, 0, 2'b00, 0, 2'b00, op, 0, 2'b00)); tag_q.push_back({nm, "_memwr"});
        end
      end
      2'b00: begin
        exp_q.push_back(vec(0, 0, 0, 0, 2'b00, 0, fn[5] ? 2'b01 : 2'b00, op, 0, aluc));
        tag_q.push_back({nm, "_execute"});
        exp_q.push_back(vec(ce && !nw && rd == 4'hF, 0, 0, 0, 2'b00, 0, 2'b00, op, ce && !nw, 2'b00));
        tag_q.push_back({nm, "_aluwb"});
      end
      2'b10: begin
        exp_q.push_back(vec(ce, 0, 0, 0, 2'b10, 0, 2'b01, op, 0, 2'b00)); tag_q.push_back({nm, "_branch"});
      end
      default: begin
        exp_q.push_back(vec(0, 0, 0, 0, 2'b00, 0, 2'b00, op, 0, 2'b00)); tag_q.push_back({nm, "_unknown"});
      end
    endcase
    i = 0;
    while (exp_q.size() > 0) begin
      if (i == abort_at) begin
        reset_n = 1'b0;
        #1;
        check({nm, "_reset_abort"}, vec(0, 0, 0, 0, 2'b10, 1, 2'b10, op, 0, 2'b00));
        exp_q.delete(); tag_q.delete();
        mflags = 4'b0000;
        @(negedge clk);
        reset_n = 1'b1;
        return;
      end
      #1;
      check(tag_q.pop_front(), exp_q.pop_front());
      @(negedge clk);
      i++;
    end
    if (op == 2'b00 && s && ce && known) begin
      mflags[3:2] = af[3:2];
      if (arith) mflags[1:0] = af[1:0];
    end
  endtask

  initial begin
    logic [3:0] pats[6];
    pats[0] = 4'b0000; pats[1] = 4'b0100; pats[2] = 4'b1000;
    pats[3] = 4'b0010; pats[4] = 4'b1001; pats[5] = 4'b0111;
    reset_n = 1'b0; Cond = 4'hE; Op = 2'b00; Funct = 6'd0; Rd = 4'd0; ALUFlags = 4'd0;
    mflags = 4'b0000;
    repeat (2) @(negedge clk);
    #1;
    check("reset_state", vec(0, 0, 0, 0, 2'b10, 1, 2'b10, 2'b00, 0, 2'b00));
    @(negedge clk);
    reset_n = 1'b1;

    run_instr("beq_after_reset", 4'h0, 2'b10, 6'd0, 4'd0, 4'd0, -1);
    run_instr("adds_r1", 4'hE, 2'b00, 6'b001001, 4'd1, 4'b0100, -1);
    run_instr("cmp_imm", 4'hE, 2'b00, 6'b110101, 4'd0, 4'b0100, -1);
    run_instr("beq_taken", 4'h0, 2'b10, 6'd0, 4'd0, 4'd0, -1);
    run_instr("bne_not", 4'h1, 2'b10, 6'd0, 4'd0, 4'd0, -1);
    run_instr("ldr_r3", 4'hE, 2'b01, 6'b011001, 4'd3, 4'd0, -1);
    run_instr("adds_clrz", 4'hE, 2'b00, 6'b001001, 4'd2, 4'b0000, -1);
    run_instr("streq_skip", 4'h0, 2'b01, 6'b011000, 4'd4, 4'd0, -1);
    run_instr("str_al", 4'hE, 2'b01, 6'b011000, 4'd4, 4'd0, -1);
    run_instr("add_pc", 4'hE, 2'b00, 6'b001000, 4'hF, 4'd0, -1);
    run_instr("ldr_pc", 4'hE, 2'b01, 6'b011001, 4'hF, 4'd0, -1);
    run_instr("op11", 4'hE, 2'b11, 6'b111111, 4'd5, 4'd0, -1);
    run_instr("adds_nv", 4'hF, 2'b00, 6'b001001, 4'd1, 4'b1111, -1);
    run_instr("bne_after_nv", 4'h1, 2'b10, 6'd0, 4'd0, 4'd0, -1);
    run_instr("subs", 4'hE, 2'b00, 6'b000101, 4'd1, 4'b1001, -1);
    run_instr("ands", 4'hE, 2'b00, 6'b000001, 4'd1, 4'b0110, -1);
    run_instr("orr", 4'hE, 2'b00, 6'b011000, 4'd1, 4'b1111, -1);
    run_instr("eors_unk", 4'hE, 2'b00, 6'b000011, 4'd1, 4'b1111, -1);
    run_instr("bvs_chk", 4'h6, 2'b10, 6'd0, 4'd0, 4'd0, -1);
    run_instr("beq_chk", 4'h0, 2'b10, 6'd0, 4'd0, 4'd0, -1);

    foreach (pats[p]) begin
      run_instr($sformatf("set_flags_%b", pats[p]), 4'hE, 2'b00, 6'b000101, 4'd0, pats[p], -1);
      for (int c = 0; c < 16; c++)
        run_instr($sformatf("b_cond%0d_f%b", c, pats[p]), c[3:0], 2'b10, 6'd0, 4'd0, 4'd0, -1);
    end

    run_instr("cmp_setz", 4'hE, 2'b00, 6'b110101, 4'd0, 4'b0100, -1);
    run_instr("ldr_abort_memrd", 4'hE, 2'b01, 6'b011001, 4'd3, 4'd0, 3);
    run_instr("beq_post_reset1", 4'h0, 2'b10, 6'd0, 4'd0, 4'd0, -1);
    run_instr("cmp_setz2", 4'hE, 2'b00, 6'b110101, 4'd0, 4'b0100, -1);
    run_instr("ldr_abort_memwb", 4'hE, 2'b01, 6'b011001, 4'd3, 4'd0, 4);
    run_instr("str_abort_memwr", 4'hE, 2'b01, 6'b011000, 4'd3, 4'd0, 3);
    run_instr("add_abort_aluwb", 4'hE, 2'b00, 6'b001000, 4'hF, 4'd0, 3);
    run_instr("beq_post_reset2", 4'h0, 2'b10, 6'd0, 4'd0, 4'd0, -1);
    run_instr("adds_final", 4'hE, 2'b00, 6'b001001, 4'd1, 4'b0100, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
